msg_recorder: RTL and testbench

//  Sink for the piano note-message bus (clk_msg strobe + msg[7:0]; msg[7]=note-on, msg[6:0]=note id).

---
 rtl/piano_pkg.sv | 18 +
 rtl/msg_sync.sv | 41 ++++
 rtl/msg_recorder.sv | 162 ++++++++++++++++
 tb/tb_msg_recorder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// Shared definitions for the piano note-message bus.
// A message is 8 bits: bit 7 = note-on flag, bits 6:0 = note id.
// Recorded buffer entries are laid out as {dt, msg}, with msg in the low bits.
package piano_pkg;

    localparam int MSG_ON_BIT = 7;
    localparam int MSG_ID_W   = 7;
    localparam int MSG_W      = 8;

    // Recorder control states. The encoding is visible on the recorder's debug output.
    typedef enum logic [1:0] {
        REC_IDLE      = 2'd0,
        REC_ARMED     = 2'd1,
        REC_RECORDING = 2'd2,
        REC_FULL      = 2'd3
    } rec_state_t;

endpackage

// File: rtl/msg_sync.sv
// Brings the asynchronous clk_msg strobe into the clk domain.
// A 2-FF synchroniser is followed by a rising-edge detector, so each strobe
// rise gives one evt pulse no matter how long the strobe stays high.
// msg is sampled every clock. During the detect cycle evt_msg_o therefore
// holds the value taken one clock earlier, which is inside the window where
// the sender keeps msg stable.
module msg_sync
    import piano_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clk_msg_i,
    input  logic [MSG_W-1:0] msg_i,
    output logic             evt_o,
    output logic [MSG_W-1:0] evt_msg_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic             prev_q;
    logic [MSG_W-1:0] msg_q;

    // Synchroniser chain, edge-detect history and message capture register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            msg_q   <= '0;
        end else begin
            sync1_q <= clk_msg_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            msg_q   <= msg_i;
        end
    end

    assign evt_o     = sync2_q & ~prev_q;
    assign evt_msg_o = msg_q;

endmodule

// File: rtl/msg_recorder.sv
// Records note-bus events into an on-chip buffer. Each entry is stored as
// {delta-ticks since the previous event, msg}.
// A random-access registered read port serves a later playback source.
// Everything runs on clk. clk_msg is only ever sampled as data.
module msg_recorder
    import piano_pkg::*;
#(
    parameter int CLK_FREQ = 120_000_000,
    parameter int TICK_HZ  = 1000,
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = 8,
    parameter int DT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rec_en,
    input  logic                  clk_msg,
    input  logic [MSG_W-1:0]      msg,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DT_W+MSG_W-1:0] rd_data,
    output logic                  rd_valid,
    output logic [ADDR_W:0]       count,
    output logic                  recording,
    output logic                  full,
    output logic                  overflow,
    output logic [1:0]            dbg_state
);

    localparam int DIV     = CLK_FREQ / TICK_HZ;
    localparam int PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int ENTRY_W = DT_W + MSG_W;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [ADDR_W:0]  DEPTH_C  = (ADDR_W + 1)'(DEPTH);

    logic             evt;
    logic [MSG_W-1:0] evt_msg;

    msg_sync u_sync (
        .clk_i     (clk),
        .rst_i     (rst),
        .clk_msg_i (clk_msg),
        .msg_i     (msg),
        .evt_o     (evt),
        .evt_msg_o (evt_msg)
    );

    // Timestamp prescaler: counts 0..DIV-1 and produces tick on the wrap.
    logic [PRE_W-1:0] presc_q;
    logic             tick;
    assign tick = (presc_q == PRE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) presc_q <= '0;
        else     presc_q <= tick ? '0 : presc_q + 1'b1;
    end

    rec_state_t        state_q;
    logic [ADDR_W:0]   count_q;
    logic              full_q;
    logic              overflow_q;
    logic              recording_q;
    logic              rec_en_q;
    logic [DT_W-1:0]   dt_cnt_q;

    logic              rec_rise;
    logic              wr_en;
    logic [DT_W-1:0]   wr_dt;
    logic [DT_W-1:0]   dt_run_d;
    logic [ADDR_W:0]   count_inc;

    // Write decision and saturating dt advance. A write uses the pre-tick dt value.
    always_comb begin
        dt_run_d = dt_cnt_q;
        if (tick && (dt_cnt_q != {DT_W{1'b1}})) dt_run_d = dt_cnt_q + 1'b1;
        rec_rise  = rec_en & ~rec_en_q;
        wr_en     = evt & rec_en & ((state_q == REC_ARMED) || (state_q == REC_RECORDING));
        wr_dt     = (state_q == REC_ARMED) ? '0 : dt_cnt_q;
        count_inc = count_q + 1'b1;
    end

    // Recorder FSM with registered status outputs.
    // Dropping rec_en wins over everything, so an event in that cycle is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= REC_IDLE;
            count_q     <= '0;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            recording_q <= 1'b0;
            rec_en_q    <= 1'b0;
            dt_cnt_q    <= '0;
        end else begin
            rec_en_q <= rec_en;
            dt_cnt_q <= dt_run_d;
            if (!rec_en) begin
                state_q     <= REC_IDLE;
                recording_q <= 1'b0;
            end else begin
                case (state_q)
                    REC_IDLE: begin
                        if (rec_rise) begin
                            count_q     <= '0;
                            full_q      <= 1'b0;
                            overflow_q  <= 1'b0;
                            dt_cnt_q    <= '0;
                            state_q     <= REC_ARMED;
                            recording_q <= 1'b1;
                        end
                    end
                    REC_ARMED, REC_RECORDING: begin
                        if (wr_en) begin
                            count_q  <= count_inc;
                            dt_cnt_q <= '0;
                            if (count_inc == DEPTH_C) begin
                                full_q      <= 1'b1;
                                state_q     <= REC_FULL;
                                recording_q <= 1'b0;
                            end else begin
                                state_q <= REC_RECORDING;
                            end
                        end
                    end
                    REC_FULL: begin
                        if (evt) overflow_q <= 1'b1;
                    end
                    default: state_q <= REC_IDLE;
                endcase
            end
        end
    end

    // Simple dual-port buffer: the write port sits at address count.
    // It has no reset so that it maps onto block RAM.
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[count_q[ADDR_W-1:0]] <= {wr_dt, evt_msg};
    end

    // Registered read port. A same-address read during a write returns the old word.
    logic [ENTRY_W-1:0] rd_data_q;
    logic               rd_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= mem_q[rd_addr];
            rd_valid_q <= ({1'b0, rd_addr} < count_q);
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign count     = count_q;
    assign recording = recording_q;
    assign full      = full_q;
    assign overflow  = overflow_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_msg_recorder.sv
// Directed bench for msg_recorder.
// Two instances share all inputs and both use CLK_FREQ=1000 and TICK_HZ=100,
// so a tick occurs every 10 clk.
//   u_a: DEPTH=4, DT_W=16
//   u_b: DEPTH=4, DT_W=4, so its dt saturates at 15.
// The prescaler starts at 0 when reset is released, so ticks land on clock
// edges 10, 20, 30, ... counted from that release. Each strobe rises at
// cycle 2 mod 10, so the buffer write lands on edge 5 mod 10. The number of
// ticks between two writes is then exact.
module tb_msg_recorder;
    import piano_pkg::*;

    logic        clk;
    logic        rst;
    logic        rec_en;
    logic        clk_msg;
    logic [7:0]  msg;
    logic [1:0]  rd_addr;

    logic [23:0] rd_data_a;
    logic        rd_valid_a, recording_a, full_a, overflow_a;
    logic [2:0]  count_a;
    logic [1:0]  dbg_state_a;

    logic [11:0] rd_data_b;
    logic        rd_valid_b, recording_b, full_b, overflow_b;
    logic [2:0]  count_b;
    logic [1:0]  dbg_state_b;

    int checks   = 0;
    int failures = 0;
    int cyc;
    int t;

    logic [23:0] exp_a_q[$];
    logic [11:0] exp_b_q[$];

    msg_recorder #(.CLK_FREQ(1000), .TICK_HZ(100), .DEPTH(4), .ADDR_W(2), .DT_W(16)) u_a (
        .clk(clk), .rst(rst), .rec_en(rec_en), .clk_msg(clk_msg), .msg(msg),
        .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .count(count_a), .recording(recording_a), .full(full_a),
        .overflow(overflow_a), .dbg_state(dbg_state_a)
    );

    msg_recorder #(.CLK_FREQ(1000), .TICK_HZ(100), .DEPTH(4), .ADDR_W(2), .DT_W(4)) u_b (
        .clk(clk), .rst(rst), .rec_en(rec_en), .clk_msg(clk_msg), .msg(msg),
        .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .count(count_b), .recording(recording_b), .full(full_b),
        .overflow(overflow_b), .dbg_state(dbg_state_b)
    );

    // Clock and cycle counter (edges since reset release).
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Watchdog: the whole run is a few thousand cycles.
    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int next_slot();
        return ((cyc / 10) + 2) * 10 + 2;
    endfunction

    // Pulse the strobe at cycle t, with msg set 5 clk beforehand and held afterwards.
    task automatic send(input int ts, input logic [7:0] m);
        while (cyc < ts - 5) @(negedge clk);
        msg = m;
        while (cyc < ts) @(negedge clk);
        clk_msg = 1'b1;
        repeat (4) @(negedge clk);
        clk_msg = 1'b0;
    endtask

    // Strobe whose write cycle coincides with a change of rec_en.
    task automatic coincide(input int ts, input logic [7:0] m, input logic new_en);
        while (cyc < ts - 5) @(negedge clk);
        msg = m;
        while (cyc < ts) @(negedge clk);
        clk_msg = 1'b1;
        repeat (2) @(negedge clk);
        rec_en = new_en;
        repeat (4) @(negedge clk);
        clk_msg = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Read addresses 0..n-1 and compare them against the scoreboard.
    // Address n is then expected to read back invalid.
    task automatic drain(input int n);
        logic [23:0] ea;
        logic [11:0] eb;
        chk("queue_len_a", exp_a_q.size(), n);
        chk("queue_len_b", exp_b_q.size(), n);
        for (int i = 0; i < n; i++) begin
            rd_addr = 2'(i);
            @(negedge clk);
            ea = (exp_a_q.size() > 0) ? exp_a_q.pop_front() : 24'hxxxxxx;
            eb = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : 12'hxxx;
            chk("rd_valid_a", rd_valid_a, 1);
            chk("rd_data_a", rd_data_a, ea);
            chk("rd_data_b", rd_data_b, eb);
        end
        if (n < 4) begin
            rd_addr = 2'(n);
            @(negedge clk);
            chk("rd_valid_past_count", rd_valid_a, 0);
        end
    endtask

    initial begin
        rst = 1'b1; rec_en = 1'b0; clk_msg = 1'b0; msg = 8'h00; rd_addr = 2'd0;
        repeat (3) @(negedge clk);
        chk("reset_count", count_a, 0);
        chk("reset_full", full_a, 0);
        chk("reset_overflow", overflow_a, 0);
        chk("reset_recording", recording_a, 0);
        chk("reset_rd_valid", rd_valid_a, 0);
        chk("reset_rd_data", rd_data_a, 0);
        chk("reset_state", dbg_state_a, REC_IDLE);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1. Three events 50 ticks apart, note-off included.
        rec_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("t1_armed", dbg_state_a, REC_ARMED);
        chk("t1_recording", recording_a, 1);
        t = next_slot();
        send(t, 8'h85);        exp_a_q.push_back({16'd0,  8'h85}); exp_b_q.push_back({4'd0,  8'h85});
        send(t + 500, 8'h05);  exp_a_q.push_back({16'd50, 8'h05}); exp_b_q.push_back({4'd15, 8'h05});
        send(t + 1000, 8'h87); exp_a_q.push_back({16'd50, 8'h87}); exp_b_q.push_back({4'd15, 8'h87});
        repeat (6) @(negedge clk);
        chk("t1_count", count_a, 3);
        chk("t1_full", full_a, 0);
        chk("t1_state", dbg_state_a, REC_RECORDING);
        drain(3);

        // 2/3. Re-arm, then fill to DEPTH, overflow once, and exercise dt 12/20/1.
        rec_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("t2_held_count", count_a, 3);
        chk("t2_idle_recording", recording_a, 0);
        rec_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("t2_rearm_count", count_a, 0);
        t = next_slot();
        send(t, 8'h90);       exp_a_q.push_back({16'd0,  8'h90}); exp_b_q.push_back({4'd0,  8'h90});
        send(t + 120, 8'h10); exp_a_q.push_back({16'd12, 8'h10}); exp_b_q.push_back({4'd12, 8'h10});
        send(t + 320, 8'hA5); exp_a_q.push_back({16'd20, 8'hA5}); exp_b_q.push_back({4'd15, 8'hA5});
        send(t + 330, 8'h25); exp_a_q.push_back({16'd1,  8'h25}); exp_b_q.push_back({4'd1,  8'h25});
        send(t + 340, 8'hC0);
        repeat (6) @(negedge clk);
        chk("t2_count", count_a, 4);
        chk("t2_full", full_a, 1);
        chk("t2_overflow", overflow_a, 1);
        chk("t2_full_not_recording", recording_a, 0);
        chk("t2_state", dbg_state_a, REC_FULL);
        chk("t2_overflow_b", overflow_b, 1);
        drain(4);
        rec_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("t2_full_held", full_a, 1);
        chk("t2_overflow_held", overflow_a, 1);
        rec_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("t2_clear_count", count_a, 0);
        chk("t2_clear_full", full_a, 0);
        chk("t2_clear_overflow", overflow_a, 0);
        chk("t2_clear_recording", recording_a, 1);

        // 4. Long strobe gives exactly one entry; events with rec_en=0 are ignored.
        msg = 8'h3C;
        repeat (6) @(negedge clk);
        clk_msg = 1'b1;
        repeat (40) @(negedge clk);
        clk_msg = 1'b0;
        repeat (6) @(negedge clk);
        exp_a_q.push_back({16'd0, 8'h3C}); exp_b_q.push_back({4'd0, 8'h3C});
        chk("t4_long_count", count_a, 1);
        drain(1);
        rec_en = 1'b0;
        repeat (2) @(negedge clk);
        send(next_slot(), 8'h41);
        send(next_slot(), 8'h42);
        repeat (6) @(negedge clk);
        chk("t4_disabled_count", count_a, 1);

        // 5. Reset in the middle of a take, then record again from address 0.
        rec_en = 1'b1;
        repeat (2) @(negedge clk);
        t = next_slot();
        send(t, 8'h11);
        send(t + 50, 8'h12);
        rd_addr = 2'd0;
        msg = 8'h13;
        while (cyc < t + 100) @(negedge clk);
        clk_msg = 1'b1;
        @(negedge clk);
        chk("t5_pre_reset_count", count_a, 2);
        rst = 1'b1;
        #1;
        chk("t5_rst_count", count_a, 0);
        chk("t5_rst_recording", recording_a, 0);
        chk("t5_rst_rd_valid", rd_valid_a, 0);
        chk("t5_rst_rd_data", rd_data_a, 0);
        chk("t5_rst_state", dbg_state_a, REC_IDLE);
        rec_en = 1'b0;
        clk_msg = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_post_state", dbg_state_a, REC_IDLE);
        chk("t5_post_count", count_a, 0);
        rec_en = 1'b1;
        repeat (2) @(negedge clk);
        send(next_slot(), 8'h14);
        exp_a_q.push_back({16'd0, 8'h14}); exp_b_q.push_back({4'd0, 8'h14});
        repeat (6) @(negedge clk);
        chk("t5_rearm_count", count_a, 1);
        drain(1);

        // 6. Events coincident with the rec_en fall and with the re-arm rise are dropped.
        coincide(next_slot(), 8'h55, 1'b0);
        chk("t6_fall_count", count_a, 1);
        chk("t6_fall_state", dbg_state_a, REC_IDLE);
        coincide(next_slot(), 8'h66, 1'b1);
        chk("t6_rise_count", count_a, 0);
        chk("t6_rise_state", dbg_state_a, REC_ARMED);
        send(next_slot(), 8'h77);
        exp_a_q.push_back({16'd0, 8'h77}); exp_b_q.push_back({4'd0, 8'h77});
        repeat (6) @(negedge clk);
        chk("t6_after_count", count_a, 1);
        drain(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
